// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard unit: a per-register remaining-stall counter scoreboard
// plus a fetch-squash counter for taken branches and issued jumps.
module hazard_scoreboard #(
  parameter int ADDR_W    = 5,
  parameter int MAX_LAT   = 7,
  parameter int ZERO_REG  = 1,
  parameter int FLUSH_CYC = 2,
  parameter int JMP_CYC   = 1,
  localparam int LAT_W    = $clog2(MAX_LAT + 1),
  localparam int NREG     = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              id_use_src1,
  input  logic              id_use_src2,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic [LAT_W-1:0]  id_lat,
  input  logic              id_is_jmp,
  input  logic              exe_br_taken,
  output logic              stall,
  output logic              issue,
  output logic              flush,
  output logic [NREG-1:0]   busy_vec
);

  localparam int FMAX = (FLUSH_CYC > JMP_CYC) ? FLUSH_CYC : JMP_CYC;
  localparam int FW   = (FMAX < 1) ? 1 : $clog2(FMAX + 1);

  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [LAT_W-1:0] lat_sat;
  logic             load_en;

  assign flush = (fcnt_q != '0);

  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush) begin
      stall = (id_use_src1 && busy_vec[id_src1]) ||
              (id_use_src2 && busy_vec[id_src2]) ||
              (id_wb_en    && busy_vec[id_dest]);
    end
  end

  assign issue = id_valid && !stall && !flush;

  // Requested latencies beyond MAX_LAT saturate; zero latency means fully forwarded.
  assign lat_sat = (id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_lat;
  assign load_en = issue && id_wb_en && (id_lat != '0);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
      assign busy_vec[gi] = 1'b0;
    end else begin : g_cnt
      logic [LAT_W-1:0] cnt_q, cnt_d;

      // The WAW stall guarantees the counter is idle whenever a load hits it.
      always_comb begin
        cnt_d = cnt_q;
        if (load_en && (id_dest == ADDR_W'(gi))) begin
          cnt_d = lat_sat;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign busy_vec[gi] = (cnt_q != '0);
    end
  end

  // A taken branch always wins and restarts the squash window.
  always_comb begin
    fcnt_d = fcnt_q;
    if (exe_br_taken) begin
      fcnt_d = FW'(FLUSH_CYC);
    end else if (issue && id_is_jmp) begin
      fcnt_d = FW'(JMP_CYC);
    end else if (fcnt_q != '0) begin
      fcnt_d = fcnt_q - FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised issue-stage hazard unit for the pipelined MIPS core. It replaces fixed EXE/MEM destination compares with a per-register scoreboard of remaining-stall counters, so the core supports producers of any latency: ALU, load, or multi-cycle units. It also owns a control-redirect flush counter covering branch and jump penalties. It sits beside the ID stage and drives the IF/ID stall and flush controls.

## Interface
Parameters:
- ADDR_W, 5, register-address width; 2**ADDR_W registers tracked
- MAX_LAT, 7, largest legal stall latency; counter width LAT_W = clog2(MAX_LAT+1)
- ZERO_REG, 1, when 1 register 0 is never busy and never tracked
- FLUSH_CYC, 2, cycles of fetch squash after a taken branch
- JMP_CYC, 1, cycles of fetch squash after an issued jump

Ports (clock and reset first; single clock; reset asynchronous, active-low):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- id_valid  in  1  instruction present in ID
- id_src1, id_src2  in  ADDR_W  source registers
- id_use_src1, id_use_src2  in  1  source actually read
- id_dest  in  ADDR_W  destination register
- id_wb_en  in  1  instruction writes id_dest
- id_lat  in  LAT_W  stall cycles a back-to-back dependent must wait (0 = full forwarding)
- id_is_jmp  in  1  ID instruction is a jump
- exe_br_taken  in  1  branch resolved taken in EXE
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EXE
- issue  out  1  ID instruction advances this cycle
- flush  out  1  squash IF/ID contents
- busy_vec  out  2**ADDR_W  bit r = register r has a pending result (debug)

## Operation
- State: cnt[r] (LAT_W bits) per register; fcnt (flush counter, width fits max(FLUSH_CYC, JMP_CYC)).
- busy(r) = (cnt[r] != 0) and not (ZERO_REG and r == 0).
- flush = (fcnt != 0).
- stall = id_valid and not flush, and any of:
  - id_use_src1 and busy(id_src1)
  - id_use_src2 and busy(id_src2)
  - id_wb_en and busy(id_dest) (WAW ordering)
- issue = id_valid and not stall and not flush.
- stall, issue, flush and busy_vec are combinational from state and inputs.
- Every cycle, each nonzero cnt[r] decrements by 1 in parallel.
- On issue with id_wb_en, when id_dest is trackable (not register 0 with ZERO_REG=1): cnt[id_dest] <= min(id_lat, MAX_LAT). This load wins over the decrement; the WAW check guarantees cnt[id_dest] was already 0.
- id_lat = 0: no counter update; the result is forwarded with no stall.
- fcnt:
  - exe_br_taken loads FLUSH_CYC.
  - Otherwise, issue and id_is_jmp load JMP_CYC.
  - Otherwise fcnt decrements if nonzero.
  - exe_br_taken always has priority; a new redirect during an active flush reloads fcnt and does not accumulate.
- While flush=1, the ID instruction is squashed: no issue, no stall, no scoreboard load. Counters keep decrementing.
- Reset (asserted at any time, including mid-operation): all cnt = 0, fcnt = 0. Hence stall=0, issue=id_valid, flush=0, busy_vec=0 while the inputs are idle.

## Timing
- Producer issued in cycle t with id_lat=L: cnt=L in cycle t+1, and the register is free in cycle t+1+L. A dependent in ID at t+1 stalls exactly L cycles and issues in t+1+L.
- exe_br_taken in cycle t: flush=1 in cycles t+1 .. t+FLUSH_CYC.
- Jump issued in cycle t: flush=1 in cycles t+1 .. t+JMP_CYC.
- Reset deassertion: scoreboard live from the first rising edge after rst goes high. Outputs reflect reset state asynchronously while rst=0.

## Test plan
- Load-use: cycle 0, issue dest=8 id_lat=1. Cycle 1, id_src1=8 -> stall=1, issue=0. Cycle 2 -> stall=0, issue=1.
- Long latency plus parallel decrement: cycle 0, dest=3 lat=4. Cycle 1, dest=5 lat=1. busy_vec bit5 clears at cycle 3 and bit3 at cycle 5. A consumer of r3 stalls cycles 1-4.
- Register 0 and WAW:
  - Write r0 lat=3, then read r0 -> no stall, busy_vec=0.
  - dest=9 lat=2, then write to r9 -> stall 2 cycles.
- Branch flush: exe_br_taken at cycle 10 -> flush=1 in cycles 11-12, issue=0 despite id_valid, no scoreboard load. A second exe_br_taken at cycle 11 extends flush through cycle 13.
- Jump, with exe_br_taken in the same cycle -> fcnt loads FLUSH_CYC, not JMP_CYC.
- Reset mid-operation: with r4 busy (cnt=3) and fcnt=1, pulse rst low asynchronously -> busy_vec=0 and flush=0 immediately. The next cycle a reader of r4 issues without stall.
